// File: rtl/fft_dec_pkg.sv
// Shared types and width helpers for the dominant-frequency detector.
// FFTDEC_MAGSQ_EN selects squared magnitude instead of |re|+|im|.
package fft_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic int mag_width(input int bw);
`ifdef FFTDEC_MAGSQ_EN
        return 2 * bw + 1;
`else
        return bw + 1;
`endif
    endfunction

    // peak index is at most N-1 bits wide (positive half only)
    function automatic int prod_width(input int n, input int fs);
        return n - 1 + $clog2(fs + 1);
    endfunction

endpackage

// File: rtl/fft_mag.sv
// Combinational magnitude of one complex bin: |re|+|im|, or re^2+im^2
// when FFTDEC_MAGSQ_EN is defined.
module fft_mag
    import fft_dec_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    localparam int MW = mag_width(BIT_WIDTH)
) (
    input  logic [2*BIT_WIDTH-1:0] bin,
    output logic [MW-1:0]          mag
);

    logic signed [BIT_WIDTH-1:0] re, im;
    assign re = bin[2*BIT_WIDTH-1:BIT_WIDTH];
    assign im = bin[BIT_WIDTH-1:0];

`ifdef FFTDEC_MAGSQ_EN
    logic signed [2*BIT_WIDTH-1:0] re_sq, im_sq;
    assign re_sq = re * re;
    assign im_sq = im * im;
    assign mag   = {1'b0, re_sq} + {1'b0, im_sq};
`else
    logic [BIT_WIDTH-1:0] re_abs, im_abs;
    // negating the most negative value wraps to 2**(BIT_WIDTH-1) unsigned,
    // which is exactly the magnitude we want
    assign re_abs = re[BIT_WIDTH-1] ? -re : re;
    assign im_abs = im[BIT_WIDTH-1] ? -im : im;
    assign mag    = {1'b0, re_abs} + {1'b0, im_abs};
`endif

endmodule

// File: rtl/fft_dec.sv
// Tracks the strongest positive-frequency bin of each FFT frame and reports
// its frequency in Hz. Magnitude mode is selected by FFTDEC_MAGSQ_EN.
module fft_dec
    import fft_dec_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int FFT_SIZE  = 512,
    parameter int FS        = 48000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] fft_result,
    output logic [BIT_WIDTH:0]     frequency,
    output logic                   note_dec
);

    localparam int MW = mag_width(BIT_WIDTH);
    localparam int PW = prod_width(N, FS);
    localparam int FW = BIT_WIDTH + 1;

    state_t        state, state_nxt;
    logic [N-1:0]  cnt, idx;
    logic          frame_start, last_bin, candidate, report;
    logic [MW-1:0] mag, peak_mag;
    logic [N-2:0]  peak_idx;
    logic [PW-1:0] prod;

    fft_mag #(.BIT_WIDTH(BIT_WIDTH)) u_mag (
        .bin (fft_result),
        .mag (mag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fft_done) state_nxt = ACCUM;
            ACCUM:   if (last_bin) state_nxt = REPORT;
            // a bin arriving during REPORT is index 0 of the next frame
            REPORT:  state_nxt = fft_done ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idx         = (state == ACCUM) ? cnt : '0;
        frame_start = fft_done && (state != ACCUM);
        last_bin    = fft_done && (state == ACCUM) && (cnt == N'(FFT_SIZE - 1));
        candidate   = fft_done && (idx != '0) && (idx < N'(FFT_SIZE / 2));
        report      = (state == REPORT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cnt <= '0;
        else if (fft_done) cnt <= idx + N'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (frame_start) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (candidate && (mag > peak_mag)) begin
            peak_mag <= mag;
            peak_idx <= idx[N-2:0];
        end
    end

    assign prod = PW'(peak_idx) * PW'(FS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frequency <= '0;
            note_dec  <= 1'b0;
        end else begin
            note_dec <= report;
            if (report) frequency <= FW'(prod >> N);
        end
    end

endmodule

// File: tb/tb_fft_dec.sv
// Scoreboard bench for fft_dec: frames push expected frequency and pulse
// cycle; a negedge monitor pops and compares on every note_dec pulse.
module tb_fft_dec;

    localparam int FFT_SIZE = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fft_done = 1'b0;
    logic [31:0] fft_result = '0;
    logic [16:0] frequency;
    logic        note_dec;

    fft_dec dut (
        .clk        (clk),
        .reset      (reset),
        .fft_done   (fft_done),
        .fft_result (fft_result),
        .frequency  (frequency),
        .note_dec   (note_dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int freq;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] frame [FFT_SIZE];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (note_dec === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frequency", int'(frequency), e.freq);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < FFT_SIZE; i++) frame[i] = '0;
    endtask

    task automatic set_bin(input int idx, input int re, input int im);
        frame[idx] = {re[15:0], im[15:0]};
    endtask

    // Drive nbins bins; a complete frame queues its expected report.
    task automatic run_frame(input bit gaps, input int exp_freq, input int nbins);
        int last;
        last = 0;
        for (int i = 0; i < nbins; i++) begin
            fft_done   = 1'b1;
            fft_result = frame[i];
            @(posedge clk); #1;
            last = cyc;
            if (gaps && i != FFT_SIZE - 1) begin
                fft_done   = 1'b0;
                fft_result = '0;
                @(posedge clk); #1;
            end
        end
        fft_done   = 1'b0;
        fft_result = '0;
        if (nbins == FFT_SIZE) exp_q.push_back('{exp_freq, last + 1});
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_frequency", int'(frequency), 0);
        check("reset_note_dec", int'(note_dec), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // single tone, bin 10
        clear_frame(); set_bin(10, 1000, 0);
        run_frame(1'b0, 937, FFT_SIZE);

        // tone at bin 100 over small noise
        clear_frame();
        for (int i = 0; i < FFT_SIZE; i++) set_bin(i, i % 6, -(i % 4));
        set_bin(100, 2000, 0);
        run_frame(1'b0, 9375, FFT_SIZE);

        // tie: lowest index wins
        clear_frame(); set_bin(20, 500, -500); set_bin(30, 500, -500);
        run_frame(1'b0, 1875, FFT_SIZE);

        // DC and mirror-half rejection
        clear_frame(); set_bin(0, 30000, 0); set_bin(502, 20000, 0); set_bin(5, 100, 0);
        run_frame(1'b0, 468, FFT_SIZE);

        // gapped delivery of the single-tone frame
        clear_frame(); set_bin(10, 1000, 0);
        run_frame(1'b1, 937, FFT_SIZE);

        // all-zero frame still pulses with frequency 0
        clear_frame();
        run_frame(1'b0, 0, FFT_SIZE);

        // most negative component outranks most positive
        clear_frame(); set_bin(3, 32767, 0); set_bin(7, -32768, 0);
        run_frame(1'b0, 656, FFT_SIZE);

        // last candidate bin; bins 256 and 511 are not candidates
        clear_frame(); set_bin(255, 1, 0); set_bin(256, 30000, 0); set_bin(511, 30000, 0);
        run_frame(1'b0, 23906, FFT_SIZE);
        repeat (3) @(posedge clk);
        #1;

        // reset mid-frame: partial frame discarded, outputs cleared
        clear_frame(); set_bin(64, 3000, 0);
        run_frame(1'b0, 0, 200);
        #3 reset = 1'b0;
        #1;
        check("midreset_frequency", int'(frequency), 0);
        check("midreset_note_dec", int'(note_dec), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        run_frame(1'b0, 6000, FFT_SIZE);

        repeat (5) @(posedge clk);
        #1;
        check("pending_reports", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
